// File: rtl/debug_trace_uart.sv
// Debug write tracer: windowed bus writes are queued and sent as 9-byte 8N1 frames (A5, addr, data).
// Write at edge E gives start bit at E+2; captures that find the FIFO full are dropped and counted.
module debug_trace_uart #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] ADDR_LO    = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trace_en,
  input  logic        debug_we,
  input  logic [31:0] debug_addr,
  input  logic [31:0] debug_data,
  output logic        trace_tx,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic [63:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [32:0]   lo_diff, hi_diff;
  logic          qual, fifo_full, fifo_empty, push, pop;

  logic [71:0] frame;
  logic [7:0]  byte_cur;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [3:0]  byte_idx;
  logic        baud_done, tx_nxt, busy_nxt;

  // Window test via 33-bit borrow so the bounds stay inclusive for any parameter values.
  assign lo_diff    = {1'b0, debug_addr} - {1'b0, ADDR_LO};
  assign hi_diff    = {1'b0, ADDR_HI} - {1'b0, debug_addr};
  assign qual       = debug_we && trace_en && !lo_diff[32] && !hi_diff[32];
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = qual && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign byte_cur   = frame[71:64];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {debug_addr, debug_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Fullness is judged before any same-cycle pop, so a pop does not rescue the entry.
      if (qual && fifo_full) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (baud_done) state_nxt = DATA;
      DATA:    if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (baud_done) state_nxt = (byte_idx == 4'd8) ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // The frame register shifts up one byte per completed byte, so the byte on the wire is always [71:64].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (pop) begin
        frame    <= {8'hA5, mem[rd_ptr]};
        byte_idx <= '0;
      end
      if (state == START && baud_done) bit_idx <= '0;
      if (state == DATA && baud_done)  bit_idx <= bit_idx + 1'b1;
      if (state == STOP && baud_done && byte_idx != 4'd8) begin
        byte_idx <= byte_idx + 1'b1;
        frame    <= {frame[63:0], 8'h00};
      end
    end
  end

  always_comb begin
    tx_nxt = 1'b1;
    case (state)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = byte_cur[bit_idx];
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state != IDLE) || !fifo_empty;
  end

  // Registered line and busy keep the pin glitch-free and aligned with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trace_tx <= 1'b1;
      busy     <= 1'b0;
    end else begin
      trace_tx <= tx_nxt;
      busy     <= busy_nxt;
    end
  end
endmodule
